sm_divider: RTL and testbench

- Sequential sign-magnitude fixed-point divider: computes q = n / d in the same W-bit, FRAC-fractional format as the datapath multiplier.
- Uses the same rounding (+0.5 LSB, round half up on magnitude) and the same saturation to MAG_MAX.
- Feeds the Kalman gain path, where the innovation covariance S is divided into P·Hᵀ.
- Radix-2 restoring long division, one quotient bit per cycle, valid/ready on both sides.

---
 rtl/sm_fixed_pkg.sv | 18 +
 rtl/sm_div_step.sv | 23 ++
 rtl/sm_divider.sv | 119 +++++++++++
 tb/tb_sm_divider.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sm_fixed_pkg.sv
// Shared constants for the sign-magnitude fixed-point datapath (multiplier and divider)
// and the divider's state encoding.
package sm_fixed_pkg;

  localparam int W    = 24;
  localparam int FRAC = 14;
  localparam int QW   = W - 1 + FRAC;

  localparam logic [W-1:0] MAG_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/sm_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module sm_div_step
  import sm_fixed_pkg::*;
(
  input  logic [W-2:0] rem_in,
  input  logic         din,
  input  logic [W-2:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         qbit
);

  logic [W-1:0] shifted;
  logic [W:0]   trial;

  always_comb begin
    shifted = {rem_in, din};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    qbit    = ~trial[W];
    rem_out = qbit ? trial[W-1:0] : shifted;
  end

endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude fixed-point divider q = n / d, one quotient bit per cycle,
// rounded half-up on magnitude and saturated to MAG_MAX.
module sm_divider
  import sm_fixed_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] n_sm,
  input  logic [W-1:0] d_sm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q_sm,
  output logic         div0,
  output logic         ovf
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, and the result is held stable in DONE until out_ready.

  localparam int CW = $clog2(QW);

  div_state_e   state_q, state_d;
  logic [QW-1:0] dvd_q;
  logic [QW-1:0] quo_q;
  logic [W-1:0]  rem_q;
  logic [W-2:0]  dm_q;
  logic          sign_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  rem_next;
  logic          qbit;
  logic          round_up;
  logic [QW:0]   qr;
  logic          sat;
  logic          dz;
  logic [W-2:0]  mag;

  sm_div_step u_step (
    .rem_in  (rem_q[W-2:0]),
    .din     (dvd_q[QW-1]),
    .divisor (dm_q),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding carry past MAG_MAX is caught by comparing the widened rounded quotient.
  always_comb begin
    round_up = ({rem_q, 1'b0} >= {2'b00, dm_q});
    qr       = {1'b0, quo_q} + {{QW{1'b0}}, round_up};
    sat      = (qr > {{(QW+1-W){1'b0}}, MAG_MAX});
    dz       = (dm_q == '0);
    mag      = (dz || sat) ? MAG_MAX[W-2:0] : qr[W-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dm_q      <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      q_sm      <= '0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q  <= {n_sm[W-2:0], {FRAC{1'b0}}};
            dm_q   <= d_sm[W-2:0];
            sign_q <= n_sm[W-1] ^ d_sm[W-1];
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CW'(QW - 1);
          end
        end
        CALC: begin
          dvd_q <= {dvd_q[QW-2:0], 1'b0};
          rem_q <= rem_next;
          quo_q <= {quo_q[QW-2:0], qbit};
          cnt_q <= cnt_q - 1'b1;
        end
        ROUND: begin
          q_sm      <= {sign_q, mag};
          div0      <= dz;
          ovf       <= sat && !dz;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_divider.sv
// Directed-vector bench for sm_divider: hand-computed quotients, latency, back-pressure,
// ignored inputs while busy, and reset in the middle of a division.
module tb_sm_divider;
  import sm_fixed_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] n_sm;
  logic [W-1:0] d_sm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q_sm;
  logic         div0;
  logic         ovf;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  sm_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n_sm      (n_sm),
    .d_sm      (d_sm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_sm      (q_sm),
    .div0      (div0),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one division; hold = cycles of out_ready=0 after out_valid, noise = busy-time junk
  task automatic run_vec(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] q_exp, input logic div0_exp, input logic ovf_exp,
                         input int hold, input bit noise);
    int lat;
    logic [W-1:0] exp_val;
    exp_q.push_back(q_exp);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    n_sm     = n;
    d_sm     = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_sm     = W'($urandom);
    d_sm     = W'($urandom);
    lat      = 0;
    while (!out_valid && lat < 100) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        n_sm      = W'($urandom);
        d_sm      = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'd38);
    exp_val = exp_q.pop_front();
    check({tag, ".q"}, 32'(q_sm), 32'(exp_val));
    check({tag, ".div0"}, 32'(div0), 32'(div0_exp));
    check({tag, ".ovf"}, 32'(ovf), 32'(ovf_exp));
    check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_q"}, 32'({q_sm, div0, ovf}), 32'({exp_val, div0_exp, ovf_exp}));
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_cleared"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic reset_mid_calc();
    int stale;
    @(negedge clk);
    n_sm     = 24'h004000;
    d_sm     = 24'h008000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    check("rst_mid.q", 32'(q_sm), 32'd0);
    check("rst_mid.flags", 32'({div0, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid.in_ready_release", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_mid.stale_valid", 32'(stale), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_sm      = '0;
    d_sm      = '0;
    repeat (3) @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.q", 32'(q_sm), 32'd0);
    check("reset.flags", 32'({div0, ovf}), 32'd0);
    rst_n = 1'b1;

    run_vec("basic",      24'h004000, 24'h008000, 24'h002000, 1'b0, 1'b0, 0, 1'b0);
    run_vec("neg_pos",    24'h80C000, 24'h006000, 24'h808000, 1'b0, 1'b0, 0, 1'b0);
    run_vec("neg_neg",    24'h80C000, 24'h806000, 24'h008000, 1'b0, 1'b0, 0, 1'b0);
    run_vec("third",      24'h004000, 24'h00C000, 24'h001555, 1'b0, 1'b0, 0, 1'b0);
    run_vec("two_third",  24'h008000, 24'h00C000, 24'h002AAB, 1'b0, 1'b0, 0, 1'b0);
    run_vec("half_up",    24'h000001, 24'h008000, 24'h000001, 1'b0, 1'b0, 0, 1'b0);
    run_vec("neg_zero",   24'h800001, 24'h7FFFFF, 24'h800000, 1'b0, 1'b0, 0, 1'b0);
    run_vec("no_sat_edge",24'h0001FF, 24'h000001, 24'h7FC000, 1'b0, 1'b0, 0, 1'b0);
    run_vec("sat_edge",   24'h800200, 24'h000001, 24'hFFFFFF, 1'b0, 1'b1, 0, 1'b0);
    run_vec("sat_max",    24'h7FFFFF, 24'h000001, 24'h7FFFFF, 1'b0, 1'b1, 0, 1'b0);
    run_vec("div0_neg",   24'h804000, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0, 0, 1'b0);
    run_vec("div0_zero",  24'h000000, 24'h000000, 24'h7FFFFF, 1'b1, 1'b0, 0, 1'b0);
    run_vec("backpress",  24'h80C000, 24'h006000, 24'h808000, 1'b0, 1'b0, 10, 1'b1);
    run_vec("busy_noise", 24'h008000, 24'h00C000, 24'h002AAB, 1'b0, 1'b0, 0, 1'b1);

    reset_mid_calc();
    run_vec("after_rst",  24'h004000, 24'h00C000, 24'h001555, 1'b0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
